cellrv32_bus_arbiter_rr: RTL and testbench

// - Round-robin arbiter sharing one peripheral bus between NUM_PORTS controller ports (CPU, DMA, debug, ...).
// - Sits in front of the peripheral bus; successor to the fixed-priority two-port switch.
// - Captures strobe-style requests, grants one port at a time and routes ack/err/rdata back to it.
// - Aborts transfers that are never acknowledged after a bounded timeout.

---
 rtl/cellrv32_bus_arbiter_rr.sv | 158 +++++++++++++++
 tb/tb_cellrv32_bus_arbiter_rr.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_bus_arbiter_rr.sv
// Round-robin arbiter sharing one peripheral bus between NUM_PORTS strobe-style controller ports.
// Each grant lasts one transfer and ends on ack/err or a bounded timeout.
module cellrv32_bus_arbiter_rr #(
   parameter int         NUM_PORTS      = 4,
   parameter int         TMO_CYCLES     = 255,
   parameter logic [7:0] READ_ONLY_MASK = 8'h00
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [NUM_PORTS-1:0]          c_priv_i,
   input  logic [32*NUM_PORTS-1:0]       c_addr_i,
   input  logic [32*NUM_PORTS-1:0]       c_wdata_i,
   input  logic [4*NUM_PORTS-1:0]        c_ben_i,
   input  logic [NUM_PORTS-1:0]          c_we_i,
   input  logic [NUM_PORTS-1:0]          c_re_i,
   output logic [32*NUM_PORTS-1:0]       c_rdata_o,
   output logic [NUM_PORTS-1:0]          c_ack_o,
   output logic [NUM_PORTS-1:0]          c_err_o,
   output logic                          p_priv_o,
   output logic [$clog2(NUM_PORTS)-1:0]  p_src_o,
   output logic [31:0]                   p_addr_o,
   output logic [31:0]                   p_wdata_o,
   output logic [3:0]                    p_ben_o,
   output logic                          p_we_o,
   output logic                          p_re_o,
   input  logic [31:0]                   p_rdata_i,
   input  logic                          p_ack_i,
   input  logic                          p_err_i,
   output logic                          tmo_o
);

   localparam int SW = $clog2(NUM_PORTS);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [SW-1:0]          grant_q, grant_d;
   logic [SW-1:0]          last_q, last_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [NUM_PORTS-1:0]   pend_rd_q, pend_rd_d;
   logic [NUM_PORTS-1:0]   pend_wr_q, pend_wr_d;

   logic [NUM_PORTS-1:0]   roMask;
   logic [NUM_PORTS-1:0]   wrStrobe;
   logic [NUM_PORTS-1:0]   req;
   logic [NUM_PORTS-1:0]   grantOh;
   logic [NUM_PORTS-1:0]   ignoreVec;
   logic [NUM_PORTS-1:0]   doneVec;
   logic                   active;
   logic                   respHit;
   logic                   tmoHit;
   logic                   pickFound;
   logic [SW-1:0]          pickIdx;

   assign roMask    = READ_ONLY_MASK[NUM_PORTS-1:0];
   assign wrStrobe  = c_we_i & ~roMask;
   assign req       = pend_rd_q | pend_wr_q | c_re_i | wrStrobe;
   assign grantOh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
   assign active    = (state_q == ISSUE) || (state_q == BUSY);
   assign ignoreVec = active ? grantOh : '0;
   assign respHit   = p_ack_i | p_err_i;
   assign tmoHit    = (TMO_CYCLES != 0) && (state_q == BUSY) &&
                      (cnt_q >= 8'(TMO_CYCLES - 1)) && !respHit;
   assign doneVec   = c_ack_o | c_err_o;

   // Search starts just after the last granted port so every requester is served in turn.
   always_comb begin
      pickFound = 1'b0;
      pickIdx   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         if (!pickFound && req[(int'(last_q) + k) % NUM_PORTS]) begin
            pickFound = 1'b1;
            pickIdx   = SW'((int'(last_q) + k) % NUM_PORTS);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      pend_rd_d = (pend_rd_q | (c_re_i & ~ignoreVec)) & ~doneVec;
      pend_wr_d = (pend_wr_q | (wrStrobe & ~ignoreVec)) & ~doneVec;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (pickFound) begin
               grant_d = pickIdx;
               last_d  = pickIdx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = cnt_q + 8'd1;
            state_d = respHit ? IDLE : BUSY;
         end
         BUSY: begin
            cnt_d = cnt_q + 8'd1;
            if (respHit || tmoHit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Everything is forced low while reset is asserted, even before the registers clear.
   always_comb begin
      c_rdata_o = '0;
      c_ack_o   = '0;
      c_err_o   = '0;
      p_priv_o  = 1'b0;
      p_src_o   = '0;
      p_addr_o  = '0;
      p_wdata_o = '0;
      p_ben_o   = '0;
      p_we_o    = 1'b0;
      p_re_o    = 1'b0;
      tmo_o     = 1'b0;
      if (rstn_i) begin
         p_src_o   = grant_q;
         p_priv_o  = c_priv_i[grant_q];
         p_addr_o  = c_addr_i[32*int'(grant_q) +: 32];
         p_wdata_o = c_wdata_i[32*int'(grant_q) +: 32];
         p_ben_o   = c_ben_i[4*int'(grant_q) +: 4];
         if (state_q == ISSUE) begin
            p_we_o = pend_wr_q[grant_q];
            p_re_o = pend_rd_q[grant_q] & ~pend_wr_q[grant_q];
         end
         if (active) begin
            c_ack_o = grantOh & {NUM_PORTS{p_ack_i & ~p_err_i}};
            c_err_o = grantOh & {NUM_PORTS{p_err_i | tmoHit}};
            c_rdata_o[32*int'(grant_q) +: 32] = p_rdata_i;
            tmo_o   = tmoHit;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         last_q    <= SW'(NUM_PORTS - 1);
         cnt_q     <= '0;
         pend_rd_q <= '0;
         pend_wr_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         pend_rd_q <= pend_rd_d;
         pend_wr_q <= pend_wr_d;
      end
   end

endmodule

// File: tb/tb_cellrv32_bus_arbiter_rr.sv
// Bench for cellrv32_bus_arbiter_rr: directed scenarios then random traffic, predicted by a
// transaction-level round-robin model and checked by a decoupled scoreboard monitor.
module tb_cellrv32_bus_arbiter_rr;

   localparam int         N   = 4;
   localparam int         TMO = 8;
   localparam logic [7:0] RO  = 8'h01;

   logic            clk = 1'b0;
   logic            rstn_i = 1'b0;
   logic [N-1:0]    c_priv_i = '0;
   logic [32*N-1:0] c_addr_i = '0;
   logic [32*N-1:0] c_wdata_i = '0;
   logic [4*N-1:0]  c_ben_i = '0;
   logic [N-1:0]    c_we_i = '0;
   logic [N-1:0]    c_re_i = '0;
   logic [32*N-1:0] c_rdata_o;
   logic [N-1:0]    c_ack_o;
   logic [N-1:0]    c_err_o;
   logic            p_priv_o;
   logic [1:0]      p_src_o;
   logic [31:0]     p_addr_o;
   logic [31:0]     p_wdata_o;
   logic [3:0]      p_ben_o;
   logic            p_we_o;
   logic            p_re_o;
   logic [31:0]     p_rdata_i = '0;
   logic            p_ack_i = 1'b0;
   logic            p_err_i = 1'b0;
   logic            tmo_o;

   always #5 clk = ~clk;

   cellrv32_bus_arbiter_rr #(
      .NUM_PORTS(N), .TMO_CYCLES(TMO), .READ_ONLY_MASK(RO)
   ) dut (
      .clk_i(clk), .rstn_i(rstn_i), .c_priv_i(c_priv_i), .c_addr_i(c_addr_i),
      .c_wdata_i(c_wdata_i), .c_ben_i(c_ben_i), .c_we_i(c_we_i), .c_re_i(c_re_i),
      .c_rdata_o(c_rdata_o), .c_ack_o(c_ack_o), .c_err_o(c_err_o), .p_priv_o(p_priv_o),
      .p_src_o(p_src_o), .p_addr_o(p_addr_o), .p_wdata_o(p_wdata_o), .p_ben_o(p_ben_o),
      .p_we_o(p_we_o), .p_re_o(p_re_o), .p_rdata_i(p_rdata_i), .p_ack_i(p_ack_i),
      .p_err_i(p_err_i), .tmo_o(tmo_o)
   );

   typedef struct {
      int cyc; int src; bit wr;
      logic [31:0] addr; logic [31:0] wdata; logic [3:0] ben; bit priv;
   } issue_t;

   typedef struct {
      int cyc; int port; bit ack; bit err; bit tmo; logic [31:0] rdata;
   } resp_t;

   issue_t issueQ[$];
   resp_t  respQ[$];
   int     total = 0;
   int     bad = 0;
   int     cyc = -1;

   bit          pendRd[N];
   bit          pendWr[N];
   bit          portBusy[N];
   logic [31:0] portAddr[N];
   logic [31:0] portWdata[N];
   logic [3:0]  portBen[N];
   bit          portPriv[N];
   int          lastG = N - 1;
   int          issueC = -10;
   int          endC = -1;
   int          curPort = 0;
   int          curKind = 0;
   bit          curActive = 1'b0;
   logic [31:0] curRdata = '0;
   int          forceKind = -1;
   int          forceLat = -1;
   bit          forceIdleAck = 1'b0;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus cycle: drive ports and peripheral, then let the model decide the next grant.
   // Kinds: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout).
   task automatic applyStimulus(input logic [N-1:0] reV, input logic [N-1:0] weV);
      bit inFlight;
      bit anyPend;
      int pick;
      int lat;
      int r;
      @(posedge clk);
      #1;
      cyc++;
      rstn_i = 1'b1;
      if (curActive && cyc > endC) begin
         portBusy[curPort] = 1'b0;
         curActive = 1'b0;
      end
      inFlight = curActive && (cyc >= issueC);
      p_ack_i = 1'b0;
      p_err_i = 1'b0;
      p_rdata_i = $urandom();
      if (inFlight && cyc == endC) begin
         p_rdata_i = curRdata;
         p_ack_i = (curKind == 0) || (curKind == 2);
         p_err_i = (curKind == 1) || (curKind == 2);
      end else if (!inFlight && (forceIdleAck || $urandom_range(0, 7) == 0)) begin
         p_ack_i = 1'b1;
         p_err_i = 1'($urandom_range(0, 1));
      end
      c_re_i = reV;
      c_we_i = weV;
      for (int i = 0; i < N; i++) begin
         if ((reV[i] || weV[i]) && !portBusy[i]) begin
            portAddr[i]  = $urandom();
            portWdata[i] = $urandom();
            portBen[i]   = 4'($urandom_range(0, 15));
            portPriv[i]  = 1'($urandom_range(0, 1));
            pendRd[i]    = reV[i];
            pendWr[i]    = weV[i] && !RO[i];
            portBusy[i]  = pendRd[i] || pendWr[i];
         end
         c_addr_i[32*i +: 32]  = portAddr[i];
         c_wdata_i[32*i +: 32] = portWdata[i];
         c_ben_i[4*i +: 4]     = portBen[i];
         c_priv_i[i]           = portPriv[i];
      end
      anyPend = 1'b0;
      for (int i = 0; i < N; i++) anyPend |= pendRd[i] | pendWr[i];
      if (!curActive && anyPend) begin
         pick = -1;
         for (int k = 1; k <= N; k++)
            if (pick < 0 && (pendRd[(lastG + k) % N] || pendWr[(lastG + k) % N])) pick = (lastG + k) % N;
         lastG = pick;
         curPort = pick;
         curActive = 1'b1;
         issueC = cyc + 1;
         r = $urandom_range(0, 9);
         curKind = (forceKind >= 0) ? forceKind : (r < 6 ? 0 : (r < 8 ? 1 : (r == 8 ? 2 : 3)));
         lat = (forceLat >= 0) ? forceLat : $urandom_range(0, 7);
         endC = (curKind == 3) ? issueC + TMO - 1 : issueC + lat;
         curRdata = $urandom();
         issueQ.push_back('{issueC, pick, pendWr[pick], portAddr[pick], portWdata[pick],
                            portBen[pick], portPriv[pick]});
         respQ.push_back('{endC, pick, curKind == 0, curKind != 0, curKind == 3, curRdata});
         pendRd[pick] = 1'b0;
         pendWr[pick] = 1'b0;
      end
   endtask

   task automatic stepReset();
      @(posedge clk);
      #1;
      cyc++;
      rstn_i = 1'b0;
      c_re_i = '0;
      c_we_i = '0;
      p_ack_i = 1'b0;
      p_err_i = 1'b0;
      while (issueQ.size() > 0 && issueQ[$].cyc >= cyc) void'(issueQ.pop_back());
      while (respQ.size() > 0 && respQ[$].cyc >= cyc) void'(respQ.pop_back());
      for (int i = 0; i < N; i++) begin
         pendRd[i] = 1'b0;
         pendWr[i] = 1'b0;
         portBusy[i] = 1'b0;
      end
      curActive = 1'b0;
      lastG = N - 1;
      endC = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, '0);
   endtask

   // Scoreboard monitor: pops an expectation when the DUT presents a strobe/response or one is due.
   issue_t       mIss;
   resp_t        mResp;
   logic [N-1:0] expAck;
   logic [N-1:0] expErr;
   logic [127:0] expRd;

   always @(negedge clk) begin
      if (cyc >= 0) begin
         if (!rstn_i) begin
            checkOutput("reset_outputs", 256'({c_rdata_o, c_ack_o, c_err_o, p_priv_o, p_src_o, p_addr_o,
                        p_wdata_o, p_ben_o, p_we_o, p_re_o, tmo_o}), 256'(0));
         end else begin
            if ((p_re_o || p_we_o) || (issueQ.size() > 0 && issueQ[0].cyc <= cyc)) begin
               if (issueQ.size() == 0) begin
                  checkOutput("unexpected_issue", 256'({p_re_o, p_we_o}), 256'(0));
               end else begin
                  mIss = issueQ.pop_front();
                  checkOutput("issue_cycle", 256'(cyc), 256'(mIss.cyc));
                  checkOutput("p_src", 256'(p_src_o), 256'(mIss.src));
                  checkOutput("p_we", 256'(p_we_o), 256'(mIss.wr));
                  checkOutput("p_re", 256'(p_re_o), 256'(!mIss.wr));
                  checkOutput("p_addr", 256'(p_addr_o), 256'(mIss.addr));
                  checkOutput("p_wdata", 256'(p_wdata_o), 256'(mIss.wdata));
                  checkOutput("p_ben", 256'(p_ben_o), 256'(mIss.ben));
                  checkOutput("p_priv", 256'(p_priv_o), 256'(mIss.priv));
               end
            end
            if ((|c_ack_o) || (|c_err_o) || tmo_o || (respQ.size() > 0 && respQ[0].cyc <= cyc)) begin
               if (respQ.size() == 0) begin
                  checkOutput("unexpected_resp", 256'({c_ack_o, c_err_o, tmo_o}), 256'(0));
               end else begin
                  mResp = respQ.pop_front();
                  expAck = mResp.ack ? (N'(1) << mResp.port) : '0;
                  expErr = mResp.err ? (N'(1) << mResp.port) : '0;
                  expRd  = 128'(mResp.rdata) << (32 * mResp.port);
                  checkOutput("resp_cycle", 256'(cyc), 256'(mResp.cyc));
                  checkOutput("c_ack", 256'(c_ack_o), 256'(expAck));
                  checkOutput("c_err", 256'(c_err_o), 256'(expErr));
                  checkOutput("tmo", 256'(tmo_o), 256'(mResp.tmo));
                  checkOutput("c_rdata", 256'(c_rdata_o), 256'(expRd));
               end
            end
         end
      end
   end

   initial begin
      logic [N-1:0] re;
      logic [N-1:0] we;
      for (int i = 0; i < N; i++) begin
         portAddr[i] = '0; portWdata[i] = '0; portBen[i] = '0; portPriv[i] = 1'b0;
         pendRd[i] = 1'b0; pendWr[i] = 1'b0; portBusy[i] = 1'b0;
      end
      repeat (3) stepReset();
      idle(2);

      forceKind = 0; forceLat = 2;
      applyStimulus(4'b0100, 4'b0000);
      idle(5);

      stepReset();
      forceKind = 0; forceLat = 1;
      applyStimulus(4'b1111, 4'b0000);
      idle(16);
      applyStimulus(4'b0011, 4'b0000);
      idle(8);

      forceKind = 3; forceLat = -1;
      applyStimulus(4'b0000, 4'b0010);
      forceKind = 0; forceLat = 1;
      applyStimulus(4'b0100, 4'b0000);
      idle(14);

      forceKind = 0; forceLat = 7;
      applyStimulus(4'b1000, 4'b0000);
      idle(10);

      forceKind = 2; forceLat = 1;
      applyStimulus(4'b1000, 4'b0000);
      idle(5);

      forceKind = 0; forceLat = 0;
      applyStimulus(4'b0000, 4'b0001);
      idle(3);
      applyStimulus(4'b1000, 4'b1000);
      idle(4);
      applyStimulus(4'b0001, 4'b0001);
      idle(4);

      forceKind = 3; forceLat = -1;
      applyStimulus(4'b0100, 4'b0000);
      idle(3);
      stepReset();
      stepReset();
      forceIdleAck = 1'b1;
      applyStimulus('0, '0);
      forceIdleAck = 1'b0;
      forceKind = -1; forceLat = -1;
      applyStimulus(4'b1111, 4'b0000);
      idle(40);

      for (int n = 0; n < 3000; n++) begin
         re = '0;
         we = '0;
         for (int i = 0; i < N; i++) begin
            if (!portBusy[i] && $urandom_range(0, 5) == 0) begin
               case ($urandom_range(0, 2))
                  0: re[i] = 1'b1;
                  1: we[i] = 1'b1;
                  default: begin re[i] = 1'b1; we[i] = 1'b1; end
               endcase
            end else if (curActive && i == curPort && $urandom_range(0, 15) == 0) begin
               re[i] = 1'($urandom_range(0, 1));
               we[i] = !re[i];
            end
         end
         applyStimulus(re, we);
      end

      for (int n = 0; n < 80 && (curActive || cyc <= endC + 1); n++) applyStimulus('0, '0);
      idle(2);
      @(negedge clk);
      #1;
      checkOutput("issue_queue_drained", 256'(issueQ.size()), 256'(0));
      checkOutput("resp_queue_drained", 256'(respQ.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
